// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges the CPU fetch port and load/store port onto one
// pipelined Wishbone master. One transaction in flight, round-robin on ties,
// and a watchdog that aborts a hung bus cycle with an err pulse to the owner.
module cpu_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    // instruction fetch port
    input  logic        inst_cyc_in,
    input  logic        inst_stb_in,
    input  logic [31:0] inst_addr_in,
    output logic        inst_ack_out,
    output logic [31:0] inst_data_out,
    output logic        inst_stall_out,
    output logic        inst_err_out,
    // load/store port
    input  logic        data_stb_in,
    input  logic        data_we_in,
    input  logic [3:0]  data_be_in,
    input  logic [31:0] data_addr_in,
    input  logic [31:0] data_data_in,
    output logic        data_ack_out,
    output logic [31:0] data_data_out,
    output logic        data_err_out,
    // shared Wishbone master
    output logic        mem_cyc_out,
    output logic        mem_stb_out,
    output logic        mem_we_out,
    output logic [3:0]  mem_sel_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    input  logic        mem_ack_in,
    input  logic        mem_stall_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Counter only needs to reach TIMEOUT; it never wraps because the
    // transaction is aborted the cycle it gets there.
    localparam int               CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic             WD_EN  = (TIMEOUT != 0);

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             last;
    logic [CNT_W-1:0] wd_cnt;

    logic inst_req;
    logic data_req;
    logic busy;
    logic ack_hit;
    logic to_hit;
    logic grant;
    logic grant_data;

    assign inst_req   = inst_cyc_in & inst_stb_in;
    assign data_req   = data_stb_in;
    assign busy       = (state != IDLE);
    assign ack_hit    = busy & mem_ack_in;
    // Ack in the timeout cycle wins: the transaction completes normally.
    assign to_hit     = busy & WD_EN & (wd_cnt == TO_VAL) & ~mem_ack_in;
    assign grant      = (state == IDLE) & (inst_req | data_req);
    // On a tie the requester that did not win last time gets the bus.
    assign grant_data = data_req & (~inst_req | (last == OWN_INST));

    // Acks, errs and read data go straight through to the owning port.
    assign inst_ack_out   = ack_hit & (owner == OWN_INST);
    assign data_ack_out   = ack_hit & (owner == OWN_DATA);
    assign inst_err_out   = to_hit  & (owner == OWN_INST);
    assign data_err_out   = to_hit  & (owner == OWN_DATA);
    assign inst_data_out  = mem_data_in;
    assign data_data_out  = mem_data_in;
    assign inst_stall_out = inst_req & ~inst_ack_out;

    // Next-state: REQ holds the strobe until accepted; ack or timeout ends the cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) state_nxt = REQ;
            end
            REQ: begin
                if (ack_hit || to_hit) state_nxt = IDLE;
                else if (!mem_stall_in) state_nxt = WAIT;
            end
            WAIT: begin
                if (ack_hit || to_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, ownership, round-robin history and watchdog counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= IDLE;
            owner  <= OWN_INST;
            last   <= OWN_INST;
            wd_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner  <= grant_data;
                last   <= grant_data;
                wd_cnt <= '0;
            end else if (busy && !ack_hit && WD_EN && (wd_cnt != TO_VAL)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    // Registered bus outputs; qualifiers are captured once at grant and held.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mem_cyc_out  <= 1'b0;
            mem_stb_out  <= 1'b0;
            mem_we_out   <= 1'b0;
            mem_sel_out  <= 4'h0;
            mem_addr_out <= 32'h0;
            mem_data_out <= 32'h0;
        end else begin
            mem_cyc_out <= (state_nxt != IDLE);
            mem_stb_out <= (state_nxt == REQ);
            if (grant) begin
                mem_addr_out <= grant_data ? data_addr_in : inst_addr_in;
                mem_we_out   <= grant_data & data_we_in;
                mem_sel_out  <= grant_data ? data_be_in : 4'hF;
                mem_data_out <= grant_data ? data_data_in : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized bench for cpu_mem_arbiter against a transaction-level model:
// the model tracks one in-flight transfer by its age in cycles and decides
// grants, acks and timeouts from the arbitration rules directly.
module tb_cpu_mem_arbiter;

    localparam int TO = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        inst_cyc_in, inst_stb_in;
    logic [31:0] inst_addr_in;
    logic        inst_ack_out, inst_stall_out, inst_err_out;
    logic [31:0] inst_data_out;
    logic        data_stb_in, data_we_in;
    logic [3:0]  data_be_in;
    logic [31:0] data_addr_in, data_data_in;
    logic        data_ack_out, data_err_out;
    logic [31:0] data_data_out;
    logic        mem_cyc_out, mem_stb_out, mem_we_out;
    logic [3:0]  mem_sel_out;
    logic [31:0] mem_addr_out, mem_data_out, mem_data_in;
    logic        mem_ack_in, mem_stall_in;

    cpu_mem_arbiter #(.TIMEOUT(TO)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .inst_cyc_in    (inst_cyc_in),
        .inst_stb_in    (inst_stb_in),
        .inst_addr_in   (inst_addr_in),
        .inst_ack_out   (inst_ack_out),
        .inst_data_out  (inst_data_out),
        .inst_stall_out (inst_stall_out),
        .inst_err_out   (inst_err_out),
        .data_stb_in    (data_stb_in),
        .data_we_in     (data_we_in),
        .data_be_in     (data_be_in),
        .data_addr_in   (data_addr_in),
        .data_data_in   (data_data_in),
        .data_ack_out   (data_ack_out),
        .data_data_out  (data_data_out),
        .data_err_out   (data_err_out),
        .mem_cyc_out    (mem_cyc_out),
        .mem_stb_out    (mem_stb_out),
        .mem_we_out     (mem_we_out),
        .mem_sel_out    (mem_sel_out),
        .mem_addr_out   (mem_addr_out),
        .mem_data_out   (mem_data_out),
        .mem_data_in    (mem_data_in),
        .mem_ack_in     (mem_ack_in),
        .mem_stall_in   (mem_stall_in)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one transfer in flight, described by who owns it,
    // how many cycles since its strobe rose, and whether the strobe was taken.
    bit          m_busy, m_acc, m_owner, m_last, m_fresh, m_wd_known;
    int          m_age;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_sel;
    int          plan_stall, plan_ack;
    bit          i_pend, d_pend;
    int          n_grants;

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_owner = 0; m_last = 0; m_age = 0;
        m_fresh = 1; m_wd_known = 1;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_sel = 4'h0;
    endtask

    task automatic drive_quiet();
        inst_cyc_in = 1'b0; inst_stb_in = 1'b0; data_stb_in = 1'b0;
        i_pend = 0; d_pend = 0;
    endtask

    // One clock: drive inputs at negedge, check 1ns later, then advance the model.
    task automatic cycle(input int req_pct, input bit allow_to, input bit force_ack);
        bit ireq, dreq, ack_now, to_now, e_iack, e_dack, e_ierr, e_derr, use_data;
        int r;
        @(negedge sys_clk);
        if (!i_pend && $urandom_range(99) < req_pct) begin
            i_pend = 1;
            inst_addr_in = $urandom;
        end
        if (i_pend) begin
            inst_cyc_in = 1'b1; inst_stb_in = 1'b1;
        end else begin
            r = $urandom_range(2);
            inst_cyc_in = (r == 1); inst_stb_in = (r == 2);
        end
        if (!d_pend && $urandom_range(99) < req_pct) begin
            d_pend = 1;
            data_addr_in = $urandom;
            data_we_in   = 1'($urandom_range(1));
            data_be_in   = 4'($urandom_range(15));
            data_data_in = $urandom;
        end
        data_stb_in = d_pend;
        mem_data_in = $urandom;
        if (m_busy) begin
            mem_stall_in = (m_age < plan_stall);
            mem_ack_in   = (m_age == plan_ack);
        end else begin
            mem_stall_in = 1'($urandom_range(1));
            mem_ack_in   = force_ack ? 1'b1 : ($urandom_range(3) == 0);
        end
        #1;
        ireq    = inst_cyc_in & inst_stb_in;
        dreq    = data_stb_in;
        ack_now = m_busy && mem_ack_in;
        to_now  = m_busy && !mem_ack_in && (m_age == TO);
        e_iack  = ack_now && !m_owner;
        e_dack  = ack_now && m_owner;
        e_ierr  = to_now && !m_owner;
        e_derr  = to_now && m_owner;
        chk("mem_cyc", 32'(mem_cyc_out), 32'(m_busy));
        chk("mem_stb", 32'(mem_stb_out), 32'(m_busy && !m_acc));
        if (m_busy || m_fresh) begin
            chk("mem_addr", mem_addr_out, m_addr);
            chk("mem_we", 32'(mem_we_out), 32'(m_we));
            chk("mem_sel", 32'(mem_sel_out), 32'(m_sel));
            if (m_wd_known) chk("mem_wdata", mem_data_out, m_wdata);
        end
        chk("inst_ack", 32'(inst_ack_out), 32'(e_iack));
        chk("data_ack", 32'(data_ack_out), 32'(e_dack));
        chk("inst_err", 32'(inst_err_out), 32'(e_ierr));
        chk("data_err", 32'(data_err_out), 32'(e_derr));
        chk("inst_stall", 32'(inst_stall_out), 32'(ireq && !e_iack));
        chk("inst_rdata", inst_data_out, mem_data_in);
        chk("data_rdata", data_data_out, mem_data_in);
        if (e_iack || e_ierr) i_pend = 0;
        if (e_dack || e_derr) d_pend = 0;
        if (!m_busy) begin
            if (ireq || dreq) begin
                use_data = dreq && (!ireq || (m_last != 1'b1));
                m_owner = use_data; m_last = use_data;
                m_fresh = 0; m_busy = 1; m_acc = 0; m_age = 0;
                n_grants++;
                if (use_data) begin
                    m_addr = data_addr_in; m_we = data_we_in; m_sel = data_be_in;
                    m_wdata = data_data_in; m_wd_known = 1;
                end else begin
                    m_addr = inst_addr_in; m_we = 1'b0; m_sel = 4'hF;
                    m_wd_known = 0;
                end
                if (allow_to) begin
                    plan_stall = $urandom_range(5);
                    plan_ack   = ($urandom_range(5) == 0) ? 1000 : plan_stall + $urandom_range(3);
                end else begin
                    plan_stall = $urandom_range(3);
                    plan_ack   = plan_stall + $urandom_range(TO - plan_stall);
                end
            end
        end else if (ack_now || to_now) begin
            m_busy = 0;
        end else begin
            if (!m_acc && !mem_stall_in) m_acc = 1;
            m_age++;
        end
    endtask

    initial begin
        bit found;
        sys_rst_n = 1'b0;
        inst_addr_in = '0; data_addr_in = '0; data_data_in = '0;
        data_we_in = 1'b0; data_be_in = 4'h0;
        mem_data_in = 32'hA5A5_5A5A; mem_ack_in = 1'b1; mem_stall_in = 1'b0;
        drive_quiet();
        model_reset();
        n_grants = 0;

        // Reset state, with a stray ack on the bus that must be ignored.
        @(negedge sys_clk);
        #1;
        chk("rst_cyc", 32'(mem_cyc_out), 32'd0);
        chk("rst_stb", 32'(mem_stb_out), 32'd0);
        chk("rst_we", 32'(mem_we_out), 32'd0);
        chk("rst_sel", 32'(mem_sel_out), 32'd0);
        chk("rst_addr", mem_addr_out, 32'd0);
        chk("rst_wdata", mem_data_out, 32'd0);
        chk("rst_acks", 32'({inst_ack_out, data_ack_out}), 32'd0);
        chk("rst_errs", 32'({inst_err_out, data_err_out}), 32'd0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // Continuous contention straight out of reset: data wins the first tie.
        for (int i = 0; i < 40; i++) cycle(100, 1'b0, 1'b0);
        // Mixed traffic with stalls, late acks and timeouts.
        for (int i = 0; i < 600; i++) cycle(40, 1'b1, 1'b0);

        // Reach a WAIT cycle, then reset asynchronously in the middle of it.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle(60, 1'b0, 1'b0);
            if (m_busy && m_acc) found = 1;
        end
        chk("find_wait", 32'(found), 32'd1);
        #1 sys_rst_n = 1'b0;
        mem_ack_in = 1'b1;
        #1;
        chk("mid_rst_cyc", 32'(mem_cyc_out), 32'd0);
        chk("mid_rst_stb", 32'(mem_stb_out), 32'd0);
        chk("mid_rst_addr", mem_addr_out, 32'd0);
        chk("mid_rst_sel", 32'(mem_sel_out), 32'd0);
        chk("mid_rst_we", 32'(mem_we_out), 32'd0);
        chk("mid_rst_wdata", mem_data_out, 32'd0);
        chk("mid_rst_acks", 32'({inst_ack_out, data_ack_out}), 32'd0);
        model_reset();
        drive_quiet();
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        // Late ack after release lands in IDLE and must not reach a requester.
        cycle(0, 1'b0, 1'b1);
        cycle(0, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) cycle(50, 1'b1, 1'b0);
        chk("grants_seen", 32'(n_grants > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Arbitrates the CPU core's instruction-fetch port and load/store data port onto one shared pipelined Wishbone master. It sits between `cpu_top` and the memory/bus fabric. It allows one outstanding transaction at a time, uses round-robin fairness between the two requesters, and has a bus-timeout watchdog that ends hung cycles with an error pulse.

## Interface
- `TIMEOUT`, default 255: cycles a granted transaction may spend in REQ+WAIT before it is aborted. 0 disables the watchdog.
- `sys_clk` in 1: clock, rising edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `inst_cyc_in` in 1: fetch cycle valid.
- `inst_stb_in` in 1: fetch strobe.
- `inst_addr_in` in 32: fetch address.
- `inst_ack_out` out 1: fetch completed; data valid this cycle.
- `inst_data_out` out 32: fetched word.
- `inst_stall_out` out 1: fetch not yet completed.
- `inst_err_out` out 1: fetch aborted by timeout (1-cycle pulse).
- `data_stb_in` in 1: load/store request.
- `data_we_in` in 1: 1 = store.
- `data_be_in` in 4: byte enables.
- `data_addr_in` in 32: data address.
- `data_data_in` in 32: store data.
- `data_ack_out` out 1: load/store completed.
- `data_data_out` out 32: load data.
- `data_err_out` out 1: load/store aborted by timeout (1-cycle pulse).
- `mem_cyc_out` out 1: bus cycle.
- `mem_stb_out` out 1: bus strobe.
- `mem_we_out` out 1: bus write enable.
- `mem_sel_out` out 4: bus byte select.
- `mem_addr_out` out 32: bus address.
- `mem_data_out` out 32: bus write data.
- `mem_data_in` in 32: bus read data.
- `mem_ack_in` in 1: bus acknowledge.
- `mem_stall_in` in 1: bus stall (pipelined Wishbone).

## Operation
- **Requests.** Instruction request = `inst_cyc_in & inst_stb_in`. Data request = `data_stb_in`. Each requester holds its request and qualifiers stable until it sees its own ack or err.
- **States and owner.** The FSM has three states: IDLE, REQ, WAIT. A 1-bit `owner` register (INST/DATA) records the current grant. A 1-bit `last` register records the previous grant; its reset value is INST, so data wins the first tie.
- **IDLE:**
  - Single request: grant it.
  - Both requesting: grant the requester that is not `last`.
  - On grant: latch addr, we, sel and write data into the output registers. Instruction grants force `we=0` and `sel=4'hF`. Set `owner` and `last`, go to REQ.
- **REQ:**
  - `mem_cyc_out=1`, `mem_stb_out=1`.
  - If `mem_stall_in=0`, the strobe is accepted and the state goes to WAIT.
- **WAIT:**
  - `mem_cyc_out=1`, `mem_stb_out=0`.
  - On ack, go to IDLE.
- **Ack and read data:**
  - `mem_ack_in` is honoured in any REQ or WAIT cycle. That includes the cycle of acceptance; in that case the FSM goes REQ→IDLE directly.
  - The ack is forwarded combinationally to the owner's ack output. Read data is forwarded combinationally: `inst_data_out = data_data_out = mem_data_in`.
  - `mem_ack_in` in IDLE is ignored.
- **Watchdog:**
  - The counter clears on every grant and increments in each REQ/WAIT cycle without ack.
  - When the count reaches `TIMEOUT` with no ack, the FSM pulses the owner's err output for one cycle, drops cyc/stb in the next cycle and returns to IDLE.
  - No ack is generated for an aborted transaction. An ack in the same cycle as the timeout takes priority, and no err is raised.
- **Stall output.** `inst_stall_out = inst_cyc_in & inst_stb_in & ~inst_ack_out`.
- **Output registers.** `mem_*` outputs other than data-in paths are registered.

## Timing
- **Reset (async, immediate):**
  - FSM in IDLE, `owner=INST`, `last=INST`, counter=0.
  - All mem outputs 0: cyc, stb, we, sel=0, addr=0, data=0.
  - Both err outputs 0. Acks 0, since the FSM is in IDLE.
  - A reset mid-transaction abandons it. An ack arriving after reset release is ignored because the FSM is in IDLE.
- **Grant latency:** request seen in IDLE at cycle N → `mem_stb_out=1` at N+1.
- **Best case:** zero-wait bus (no stall, ack in the acceptance cycle) → requester ack at N+1. Throughput is one transaction per 2 cycles, because a one-cycle IDLE bubble always follows completion.
- **Stability:** `mem_addr_out`, `mem_we_out`, `mem_sel_out` and `mem_data_out` are stable from grant until IDLE re-entry.
- **Simultaneous events:**
  - A request arriving during a busy transaction waits.
  - The pending requester wins the next IDLE tie-break if it was not `last`.
  - Round-robin strictly alternates under continuous contention.
- **Err timing:** err asserts in the cycle where the count reaches `TIMEOUT`, i.e. `TIMEOUT` cycles after `mem_stb_out` first rises; `mem_cyc_out` is 0 the next cycle.

## Test plan
- **Single fetch.** Fetch of 0x0000_0040, no stall, `mem_ack_in` 1 cycle after stb with `mem_data_in=0xDEADBEEF` → `mem_stb_out` at N+1, `inst_ack_out` at N+2 with `inst_data_out=0xDEADBEEF`, IDLE at N+3, `inst_stall_out` high N..N+1.
- **Tie after reset.** Fetch 0x0 and store 0x12345678 to 0x100 with `be=4'hF` requested together after reset → data granted first (`mem_we_out=1`, `mem_sel_out=F`, `mem_addr_out=0x100`). After its ack and one IDLE cycle, the fetch is granted (`mem_we_out=0`).
- **Stall.** `mem_stall_in` high 3 cycles → `mem_stb_out` high 4 cycles with `mem_addr_out` unchanged, then WAIT; ack completes normally.
- **Timeout.** `TIMEOUT=4`, no ack → `data_err_out` single pulse 4 cycles after stb rises, `mem_cyc_out=0` next cycle, no `data_ack_out`; a later fetch completes normally.
- **Reset mid-transaction.** Assert `sys_rst_n=0` mid-WAIT → all mem outputs 0 immediately; an ack after release produces no requester ack.
- **Continuous contention.** Both requesters held for 6 transactions → grants alternate DATA, INST, DATA, INST, DATA, INST.
